// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle controller for the MultipleCPU datapath.
// Walks each instruction through IF/ID/EXE/MEM/WB, drives per-state
// control strobes, counts retired instructions and keeps a sticky halt flag.
// Build option: define ILLEGAL_OP_TRAP_EN to halt on unlisted opcodes
// instead of executing them as a NOP.
module multi_cycle_control_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             sign,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             ExtSel,
    output logic             RegWre,
    output logic [1:0]       RegDst,
    output logic             WrRegDSrc,
    output logic             DBDataSrc,
    output logic             mRD,
    output logic             mWR,
    output logic [1:0]       PCSrc,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LW  = 4'b0100,
        S_EXE_B  = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_q, state_d;

    // Opcode classification and ALU-op decode
    logic       is_rtype, is_imm, is_ls, is_branch, is_jump, is_halt, is_illegal;
    logic       dec_srca, dec_ext, br_taken;
    logic [2:0] dec_aluop;

    always_comb begin
        is_rtype   = 1'b0;
        is_imm     = 1'b0;
        is_ls      = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        dec_srca   = 1'b0;
        dec_ext    = 1'b0;
        dec_aluop  = ALU_ADD;
        br_taken   = 1'b0;
        case (op)
            OP_ADD:   is_rtype = 1'b1;
            OP_SUB:   begin is_rtype = 1'b1; dec_aluop = ALU_SUB; end
            OP_ADDIU: begin is_imm = 1'b1; dec_ext = 1'b1; end
            OP_AND:   begin is_rtype = 1'b1; dec_aluop = ALU_AND; end
            OP_ANDI:  begin is_imm = 1'b1; dec_aluop = ALU_AND; end
            OP_OR:    begin is_rtype = 1'b1; dec_aluop = ALU_OR; end
            OP_ORI:   begin is_imm = 1'b1; dec_aluop = ALU_OR; end
            OP_SLL:   begin is_rtype = 1'b1; dec_aluop = ALU_SLL; dec_srca = 1'b1; end
            OP_SLTI:  begin is_imm = 1'b1; dec_aluop = ALU_SLT; dec_ext = 1'b1; end
            OP_SW, OP_LW:   is_ls = 1'b1;
            OP_BEQ:   begin is_branch = 1'b1; br_taken = zero; end
            OP_BNE:   begin is_branch = 1'b1; br_taken = ~zero; end
            OP_BLTZ:  begin is_branch = 1'b1; br_taken = sign; end
            OP_J, OP_JR, OP_JAL: is_jump = 1'b1;
            OP_HALT:  is_halt = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control outputs; reset forces all controls low
    always_comb begin
        state_d   = state_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = 2'b00;
        case (state_q)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWre    = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                if (is_jump) begin
                    PCWre   = 1'b1;
                    PCSrc   = (op == OP_JR) ? 2'b10 : 2'b11;
                    if (op == OP_JAL) begin
                        RegWre = 1'b1;
                        RegDst = 2'b10;
                    end
                    state_d = S_IF;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_branch) begin
                    state_d = S_EXE_B;
                end else if (is_ls) begin
                    state_d = S_EXE_LS;
                end else if (is_illegal) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_EXE_AL;
`endif
                end else begin
                    state_d = S_EXE_AL;
                end
            end
            S_EXE_AL: begin
                ALUSrcA = dec_srca;
                ALUSrcB = is_imm;
                ExtSel  = dec_ext;
                ALUOp   = dec_aluop;
                state_d = S_WB_AL;
            end
            S_WB_AL: begin
                ALUSrcA   = dec_srca;
                ALUSrcB   = is_imm;
                ExtSel    = dec_ext;
                ALUOp     = dec_aluop;
                RegWre    = is_rtype | is_imm;
                RegDst    = is_rtype ? 2'b01 : 2'b00;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            S_EXE_B: begin
                ALUOp   = ALU_SUB;
                ExtSel  = 1'b1;
                PCWre   = 1'b1;
                PCSrc   = br_taken ? 2'b01 : 2'b00;
                state_d = S_IF;
            end
            S_EXE_LS: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                state_d = S_MEM;
            end
            S_MEM: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (op == OP_LW) begin
                    mRD     = 1'b1;
                    state_d = S_WB_LW;
                end else begin
                    mWR     = 1'b1;
                    PCWre   = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB_LW: begin
                mRD       = 1'b1;
                DBDataSrc = 1'b1;
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
        if (!Reset) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            InsMemRW  = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 1'b0;
            ALUOp     = ALU_ADD;
            ExtSel    = 1'b0;
            RegWre    = 1'b0;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
            DBDataSrc = 1'b0;
            mRD       = 1'b0;
            mWR       = 1'b0;
            PCSrc     = 2'b00;
        end
    end

    // Retired-instruction counter, one tick per PC update, wrapping
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            retired <= '0;
        end else if (PCWre) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Sticky halt flag, set on entry to HALT
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            halted <= 1'b0;
        end else if (state_d == S_HALT) begin
            halted <= 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit; expected control words are
// hand-computed per state. Honours ILLEGAL_OP_TRAP_EN for the unlisted-op case.
module tb_multi_cycle_control_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [5:0]  op;
    logic        zero, sign;
    logic        PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre;
    logic        WrRegDSrc, DBDataSrc, mRD, mWR, halted;
    logic [2:0]  ALUOp;
    logic [1:0]  RegDst, PCSrc;
    logic [3:0]  state;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;
    int exp_ret  = 0;

    multi_cycle_control_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .state(state),
        .retired(retired), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Observed control word, field order matches ctl()
    logic [17:0] ctl_obs;
    assign ctl_obs = {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
                      RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc};

    function automatic logic [17:0] ctl(
        input logic pcw, input logic irw, input logic imr, input logic sa,
        input logic sb, input logic [2:0] aop, input logic ext, input logic rw,
        input logic [1:0] rd, input logic wrs, input logic dbs, input logic rdm,
        input logic wrm, input logic [1:0] pcs);
        return {pcw, irw, imr, sa, sb, aop, ext, rw, rd, wrs, dbs, rdm, wrm, pcs};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs set; checks state and controls, advances one cycle
    task automatic step(input string tag, input logic [3:0] st, input logic [17:0] cv);
        #1;
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".ctl"}, 32'(ctl_obs), 32'(cv));
        @(negedge CLK);
    endtask

    task automatic retire_check(input string tag);
        exp_ret++;
        check({tag, ".retired"}, retired, 32'(exp_ret));
    endtask

    localparam logic [3:0] S_IF = 4'b0000, S_ID = 4'b0001, S_EXE_LS = 4'b0010,
                           S_MEM = 4'b0011, S_WB_LW = 4'b0100, S_EXE_B = 4'b0101,
                           S_EXE_AL = 4'b0110, S_WB_AL = 4'b0111, S_HALT = 4'b1000;

    logic [17:0] c_if, c_zero, c_wb_add, c_exe_ori, c_wb_ori, c_b_t, c_b_n;
    logic [17:0] c_ls, c_mem_sw, c_mem_lw, c_wb_lw, c_jal, c_wb_nop;

    initial begin
        c_if      = ctl(0,1,1,0,0,3'b000,0,0,2'b00,0,0,0,0,2'b00);
        c_zero    = '0;
        c_wb_add  = ctl(1,0,0,0,0,3'b000,0,1,2'b01,1,0,0,0,2'b00);
        c_exe_ori = ctl(0,0,0,0,1,3'b011,0,0,2'b00,0,0,0,0,2'b00);
        c_wb_ori  = ctl(1,0,0,0,1,3'b011,0,1,2'b00,1,0,0,0,2'b00);
        c_b_t     = ctl(1,0,0,0,0,3'b001,1,0,2'b00,0,0,0,0,2'b01);
        c_b_n     = ctl(1,0,0,0,0,3'b001,1,0,2'b00,0,0,0,0,2'b00);
        c_ls      = ctl(0,0,0,0,1,3'b000,1,0,2'b00,0,0,0,0,2'b00);
        c_mem_sw  = ctl(1,0,0,0,1,3'b000,1,0,2'b00,0,0,0,1,2'b00);
        c_mem_lw  = ctl(0,0,0,0,1,3'b000,1,0,2'b00,0,0,1,0,2'b00);
        c_wb_lw   = ctl(1,0,0,0,0,3'b000,0,1,2'b00,1,1,1,0,2'b00);
        c_jal     = ctl(1,0,0,0,0,3'b000,0,1,2'b10,0,0,0,0,2'b11);
        c_wb_nop  = ctl(1,0,0,0,0,3'b000,0,0,2'b00,1,0,0,0,2'b00);

        Reset = 1'b0; op = 6'b000000; zero = 1'b0; sign = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst.state", 32'(state), 32'(S_IF));
        check("rst.ctl", 32'(ctl_obs), 32'(c_zero));
        check("rst.retired", retired, 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        Reset = 1'b1;

        // add then ori
        op = 6'b000000;
        step("add.if", S_IF, c_if);
        step("add.id", S_ID, c_zero);
        step("add.exe", S_EXE_AL, c_zero);
        step("add.wb", S_WB_AL, c_wb_add);
        retire_check("add");
        op = 6'b010010;
        step("ori.if", S_IF, c_if);
        step("ori.id", S_ID, c_zero);
        step("ori.exe", S_EXE_AL, c_exe_ori);
        step("ori.wb", S_WB_AL, c_wb_ori);
        retire_check("ori");

        // beq taken, then not taken
        op = 6'b110100; zero = 1'b1;
        step("beqt.if", S_IF, c_if);
        step("beqt.id", S_ID, c_zero);
        step("beqt.exe", S_EXE_B, c_b_t);
        retire_check("beqt");
        zero = 1'b0;
        step("beqn.if", S_IF, c_if);
        step("beqn.id", S_ID, c_zero);
        step("beqn.exe", S_EXE_B, c_b_n);
        retire_check("beqn");

        // sw then lw
        op = 6'b110000;
        step("sw.if", S_IF, c_if);
        step("sw.id", S_ID, c_zero);
        step("sw.exe", S_EXE_LS, c_ls);
        step("sw.mem", S_MEM, c_mem_sw);
        retire_check("sw");
        op = 6'b110001;
        step("lw.if", S_IF, c_if);
        step("lw.id", S_ID, c_zero);
        step("lw.exe", S_EXE_LS, c_ls);
        step("lw.mem", S_MEM, c_mem_lw);
        step("lw.wb", S_WB_LW, c_wb_lw);
        retire_check("lw");

        // jal
        op = 6'b111010;
        step("jal.if", S_IF, c_if);
        step("jal.id", S_ID, c_jal);
        retire_check("jal");

        // unlisted opcode
        op = 6'b101010;
        step("ill.if", S_IF, c_if);
        step("ill.id", S_ID, c_zero);
`ifdef ILLEGAL_OP_TRAP_EN
        step("ill.halt", S_HALT, c_zero);
        check("ill.halted", 32'(halted), 32'd1);
        check("ill.retired", retired, 32'(exp_ret));
        Reset = 1'b0;
        #1;
        check("ill.rst.state", 32'(state), 32'(S_IF));
        check("ill.rst.retired", retired, 32'd0);
        exp_ret = 0;
        @(negedge CLK);
        Reset = 1'b1;
`else
        step("ill.exe", S_EXE_AL, c_zero);
        step("ill.wb", S_WB_AL, c_wb_nop);
        retire_check("ill");
`endif

        // halt, then reset mid-HALT
        op = 6'b111111;
        step("halt.if", S_IF, c_if);
        step("halt.id", S_ID, c_zero);
        step("halt.h0", S_HALT, c_zero);
        check("halt.halted", 32'(halted), 32'd1);
        op = 6'b000000;
        step("halt.h1", S_HALT, c_zero);
        step("halt.h2", S_HALT, c_zero);
        check("halt.frozen", retired, 32'(exp_ret));
        check("halt.sticky", 32'(halted), 32'd1);
        Reset = 1'b0;
        #1;
        check("hrst.state", 32'(state), 32'(S_IF));
        check("hrst.ctl", 32'(ctl_obs), 32'(c_zero));
        check("hrst.retired", retired, 32'd0);
        check("hrst.halted", 32'(halted), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        step("post.if", S_IF, c_if);
        step("post.id", S_ID, c_zero);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
